// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared constants, widths, scan states and the weight-bus
//               offset helper for the CNN classification stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_BITS   = 8;
    localparam int FILTER_SIZE = 5;
    localparam int NUM_CLASSES = 10;
    localparam int CHANNELS    = 3;
    localparam int BEATS       = 16;
    localparam int W_BITS      = 8;

    // Post-ReLU feature width and the accumulator width that cannot overflow
    // for 48 products plus a bias.
    localparam int IN_BITS     = DATA_BITS + 2 * FILTER_SIZE + 2;
    localparam int ACC_BITS    = IN_BITS + W_BITS + 7;

    // Zero-extended feature (IN_BITS+1) times signed weight.
    localparam int PROD_BITS   = IN_BITS + 1 + W_BITS;
    localparam int BEAT_BITS   = $clog2(BEATS);
    localparam int CLASS_BITS  = 4;

    localparam int LANE_W_BITS = CHANNELS * BEATS * W_BITS;
    localparam int W_BUS_BITS  = NUM_CLASSES * LANE_W_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // Bit offset of weight w[k][c][b] on the flattened weight bus.
    function automatic int w_offset(input int k, input int c, input int b);
        return ((k * CHANNELS + c) * BEATS + b) * W_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_argmax_classifier_if.sv
`default_nettype none
// ============================================================================
// Module      : fc_argmax_classifier_if
// Description : Feature stream, quasi-static FC parameters and the
//               classification result of the final CNN stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fc_argmax_classifier_if;
    import cnn_pkg::*;

    logic                            in_val;
    logic [CHANNELS*IN_BITS-1:0]     data_in;
    logic [W_BUS_BITS-1:0]           fc_weight;
    logic [NUM_CLASSES*W_BITS-1:0]   fc_bias;
    logic [CLASS_BITS-1:0]           decision;
    logic                            out_val;
    logic                            overrun;

    modport master (
        output in_val, data_in, fc_weight, fc_bias,
        input  decision, out_val, overrun
    );

    modport slave (
        input  in_val, data_in, fc_weight, fc_bias,
        output decision, out_val, overrun
    );

endinterface
`default_nettype wire

// File: rtl/fc_mac_lane.sv
`default_nettype none
// ============================================================================
// Module      : fc_mac_lane
// Description : One class of the fully connected layer: bias load on beat 0,
//               per-beat weight select, CHANNELS multipliers and adder chain.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_mac_lane
    import cnn_pkg::*;
(
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        in_val_i,
    input  wire logic [BEAT_BITS-1:0]        beat_i,
    input  wire logic [CHANNELS*IN_BITS-1:0] data_i,
    input  wire logic [LANE_W_BITS-1:0]      weight_i,
    input  wire logic [W_BITS-1:0]           bias_i,
    output logic signed [ACC_BITS-1:0]       sum_o
);

    logic signed [ACC_BITS-1:0]  acc_q;
    logic signed [ACC_BITS-1:0]  sum_d;
    logic signed [IN_BITS:0]     w_feat [CHANNELS];
    logic signed [W_BITS-1:0]    w_wgt  [CHANNELS];
    logic signed [PROD_BITS-1:0] w_prod [CHANNELS];

    // Running sum including this beat; beat 0 restarts from the bias.
    always_comb begin
        sum_d = (beat_i == '0) ? ACC_BITS'($signed(bias_i)) : acc_q;
        for (int c = 0; c < CHANNELS; c++) begin
            w_feat[c] = $signed({1'b0, data_i[c*IN_BITS +: IN_BITS]});
            w_wgt[c]  = $signed(weight_i[w_offset(0, c, int'(beat_i)) +: W_BITS]);
            w_prod[c] = PROD_BITS'(w_feat[c]) * PROD_BITS'(w_wgt[c]);
            sum_d     = sum_d + ACC_BITS'(w_prod[c]);
        end
    end

    // Accumulator advances only on valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (in_val_i) begin
            acc_q <= sum_d;
        end
    end

    // The top snapshots the combinational sum so beat 15's term is included.
    assign sum_o = sum_d;

endmodule
`default_nettype wire

// File: rtl/fc_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module      : fc_argmax_classifier
// Description : FC layer over 48 streamed features per image followed by a
//               sequential argmax scan driving decision/out_val/overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_argmax_classifier
    import cnn_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    fc_argmax_classifier_if.slave  bus
);

    logic [BEAT_BITS-1:0]       beat_q;
    logic signed [ACC_BITS-1:0] w_sum  [NUM_CLASSES];
    logic signed [ACC_BITS-1:0] snap_q [NUM_CLASSES];
    logic                       w_snap_evt;
    logic                       evt_q;

    scan_state_t                state_q, state_d;
    logic [CLASS_BITS-1:0]      idx_q, idx_d;
    logic signed [ACC_BITS-1:0] best_q, best_d;
    logic [CLASS_BITS-1:0]      best_idx_q, best_idx_d;
    logic [CLASS_BITS-1:0]      decision_q, decision_d;
    logic                       out_val_q, out_val_d;
    logic                       overrun_q, overrun_d;

    assign w_snap_evt = bus.in_val && (beat_q == BEAT_BITS'(BEATS - 1));

    generate
        for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
            fc_mac_lane u_lane (
                .clk      (clk),
                .rst      (rst),
                .in_val_i (bus.in_val),
                .beat_i   (beat_q),
                .data_i   (bus.data_in),
                .weight_i (bus.fc_weight[k*LANE_W_BITS +: LANE_W_BITS]),
                .bias_i   (bus.fc_bias[k*W_BITS +: W_BITS]),
                .sum_o    (w_sum[k])
            );
        end
    endgenerate

    // Beat counter: wraps 15 -> 0, moves only on valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else if (bus.in_val) begin
            beat_q <= beat_q + BEAT_BITS'(1);
        end
    end

    // Snapshot bank captures final sums on beat 15; evt_q tells the scanner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                snap_q[k] <= '0;
            end
            evt_q <= 1'b0;
        end else begin
            if (w_snap_evt) begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    snap_q[k] <= w_sum[k];
                end
            end
            evt_q <= w_snap_evt;
        end
    end

    // Scan state and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            decision_q <= '0;
            out_val_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            decision_q <= decision_d;
            out_val_q  <= out_val_d;
            overrun_q  <= overrun_d;
        end
    end

    // Argmax scan; a fresh snapshot always restarts it, discarding any
    // pending result and flagging overrun if one was in flight.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        decision_d = decision_q;
        out_val_d  = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (snap_q[idx_q] > best_q) begin
                    best_d     = snap_q[idx_q];
                    best_idx_d = idx_q;
                end
                if (idx_q == CLASS_BITS'(NUM_CLASSES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + CLASS_BITS'(1);
                end
            end
            ST_DONE: begin
                decision_d = best_idx_q;
                out_val_d  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (evt_q) begin
            if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
            state_d    = ST_SCAN;
            idx_d      = CLASS_BITS'(1);
            best_d     = snap_q[0];
            best_idx_d = '0;
            decision_d = decision_q;
            out_val_d  = 1'b0;
        end
    end

    assign bus.decision = decision_q;
    assign bus.out_val  = out_val_q;
    assign bus.overrun  = overrun_q;

endmodule
`default_nettype wire
